uart_rx: RTL
============

Name: uart_rx

Overview:
- UART 8N1 receiver; the receive-side counterpart of uart_tx.
- Samples rx_line using baud_tick_16x from baud_gen (16x oversampling).
- Validates the start bit at mid-bit, shifts data in LSB first and checks the stop bit.
- Presents the byte with a one-cycle rx_done pulse and a frame_err flag.

Parameters:
DATA_BITS, 8, number of data bits per frame (LSB first)
OVERSAMPLE, 16, baud_tick_16x pulses per bit period
MID_SAMPLE, 7, tick count (0-based) at which the start bit is validated

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  receiver enable; low forces IDLE
rx_line  input  1  serial line, asynchronous to clk, idles high
baud_tick_16x  input  1  single-clk pulse, 16 per bit period
data_out  output  DATA_BITS  last received byte, held until next frame completes
rx_busy  output  1  high whenever state != IDLE
rx_done  output  1  one-clk pulse at frame completion
frame_err  output  1  stop bit of last frame sampled 0; updated with each rx_done

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; tick_cnt=0; bit_cnt=0; shift register=0.
  - data_out=0; rx_busy=0; rx_done=0; frame_err=0.
  - Both synchronizer flops=1.
- Synchronizer: rx_line passes through 2 flops (rx_s). An edge on rx_line reaches rx_s 2 clk later. All decisions use rx_s only.
- tick_cnt (4 bit) advances only on cycles with baud_tick_16x=1. It is cleared on every state transition.
- IDLE: when en=1 and rx_s=0, go to START with tick_cnt=0.
- START: on the tick where tick_cnt==MID_SAMPLE:
  - rx_s=0: go to DATA (tick_cnt=0, bit_cnt=0).
  - rx_s=1: false start; return to IDLE, no outputs change.
- DATA: on the tick where tick_cnt==15 (mid-bit), shift rx_s into the MSB of the shift register (right shift, LSB first). Then:
  - bit_cnt==DATA_BITS-1: go to STOP.
  - otherwise: bit_cnt+1.
- STOP: on the tick where tick_cnt==15, sample rx_s. On the next clk:
  - data_out = shift register; rx_done=1 for exactly one clk; frame_err = ~rx_s.
  - rx_s=1: go to IDLE.
  - rx_s=0: go to WAIT_IDLE.
- WAIT_IDLE (break/framing recovery): stay until rx_s=1, then go to IDLE. No rx_done is generated from this state.
- Latency: rx_done rises 1 clk after the baud tick that samples the stop bit, about 9.5 bit periods after the start falling edge plus 2 clk of synchronizer delay.
- Back-to-back frames: returning to IDLE at mid-stop allows a start edge 0.5 bit later to be detected. No idle bit is required between frames.
- en=0 in any state: next clk goes to IDLE and clears the counters; no rx_done. data_out and frame_err keep their last values.
- rst mid-frame: all state and outputs take reset values immediately; the partial frame is discarded.
- Simultaneous baud tick and en falling: the en=0 abort wins.
- baud_tick_16x is ignored in IDLE and WAIT_IDLE.

Decomposition:
- Package uart_pkg holds:
  - State encoding: IDLE, START, DATA, STOP, WAIT_IDLE (3-bit).
  - DATA_BITS and OVERSAMPLE defaults.
  - MID_SAMPLE constant.
  - LAST_TICK = OVERSAMPLE-1.
- One sub-module, rx_sync: 2-flop synchronizer with reset value 1 and async active-high rst. The FSM, counters and shifter stay in uart_rx.

Test Plan:
Bench drives baud_tick_16x as a 1-clk pulse every 4 clk (bit = 64 clk), 10 ns clk, and drives frames on rx_line.
- Frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> exactly one rx_done pulse about 608 clk after the start edge; data_out=0xA5; frame_err=0; rx_busy low afterwards.
- 0xA5 immediately followed by 0xAA, no idle gap -> two rx_done pulses 640 clk apart; data_out=0xA5 then 0xAA; frame_err=0 both times.
- Low glitch on rx_line of 16 clk (4 ticks) -> rx_busy pulses, FSM returns to IDLE at tick 7; no rx_done; data_out unchanged.
- Frame 0x3C with stop bit 0, line held low 200 clk more -> rx_done with data_out=0x3C, frame_err=1; FSM in WAIT_IDLE until line high; next frame 0x55 gives frame_err=0.
- rst=1 for 3 clk during data bit 4 of 0xF0 -> outputs zero asynchronously (before the next clk edge); following frame 0x81 received correctly.
- en=0 during data bit 2 -> no rx_done, FSM in IDLE; with en=1 the next frame 0x7E is received; loopback from uart_tx (0xA5) matches.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and framing constants for the UART receiver
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
  localparam int DATA_BITS_DEFAULT = 8;
  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int MID_SAMPLE = 7;
  localparam int LAST_TICK = OVERSAMPLE_DEFAULT - 1;
endpackage

// File: rtl/rx_sync.sv
// rx_sync: two-flop synchronizer for the serial line, resets to the idle (high) level
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] ff;
  always_ff @(posedge clk or posedge rst)
    if (rst) ff <= 2'b11;
    else ff <= {ff[0], d};
  assign q = ff[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 16x oversampling, mid-bit sampling and stop-bit framing check
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int MID = MID_SAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rx_line,
  input  logic                 baud_tick_16x,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_busy,
  output logic                 rx_done,
  output logic                 frame_err
);
  localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_T = 4'(MID);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  state_t state;
  logic rx_s;
  logic [3:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  rx_sync u_sync (.clk(clk), .rst(rst), .d(rx_line), .q(rx_s));
  assign rx_busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tick_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      data_out <= '0;
      rx_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (!en) begin
        state <= IDLE;
        tick_cnt <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (!rx_s) begin
            state <= START;
            tick_cnt <= '0;
          end
          START: if (baud_tick_16x) begin
            if (tick_cnt == MID_T) begin
              state <= rx_s ? IDLE : DATA;
              tick_cnt <= '0;
              bit_cnt <= '0;
            end else tick_cnt <= tick_cnt + 4'd1;
          end
          DATA: if (baud_tick_16x) begin
            if (tick_cnt == LAST) begin
              shreg <= {rx_s, shreg[DATA_BITS-1:1]};
              tick_cnt <= '0;
              bit_cnt <= bit_cnt == LAST_BIT ? '0 : bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) state <= STOP;
            end else tick_cnt <= tick_cnt + 4'd1;
          end
          STOP: if (baud_tick_16x) begin
            if (tick_cnt == LAST) begin
              data_out <= shreg;
              rx_done <= 1'b1;
              frame_err <= ~rx_s;
              state <= rx_s ? IDLE : WAIT_IDLE;
              tick_cnt <= '0;
            end else tick_cnt <= tick_cnt + 4'd1;
          end
          WAIT_IDLE: if (rx_s) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
endmodule
